// File: rtl/fifo_burst_reader_if.sv
// Stream, occupancy and status bundle for fifo_burst_reader.
// master: the FIFO/downstream side; slave: the burst reader.
interface fifo_burst_reader_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 6
);
   logic [CNT_W-1:0] count;
   logic             flush;
   logic [WIDTH-1:0] in0_V_V_TDATA;
   logic             in0_V_V_TVALID;
   logic             in0_V_V_TREADY;
   logic [WIDTH-1:0] out_V_V_TDATA;
   logic             out_V_V_TVALID;
   logic             out_V_V_TREADY;
   logic             out_V_V_TLAST;
   logic             busy;

   modport master (
      output count, flush, in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
      input  in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, out_V_V_TLAST, busy
   );

   modport slave (
      input  count, flush, in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
      output in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, out_V_V_TLAST, busy
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: waits for BURST_LEN buffered words (or a flush / idle timeout
// for a partial burst), then drains exactly that many words through a 2-entry
// registered skid buffer, tagging the final beat with TLAST.
// Optional idle-timeout release: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_W     = 6,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TIMEOUT   = 64
) (
   input logic                ap_clk,
   input logic                ap_rst_n,
   fifo_burst_reader_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;
   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } beat_t;

   localparam logic [CNT_W-1:0] BL_C = CNT_W'(BURST_LEN);

   // Elaboration-time parameter range guard
   generate
      if (BURST_LEN < 2 || BURST_LEN >= (1 << CNT_W) || TIMEOUT == 0) begin : g_bad_param
         $error("fifo_burst_reader: parameter out of range");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic             flush_pend_q, flush_pend_d;
   beat_t            skid_q [2];
   beat_t            skid_d [2];
   logic [1:0]       vld_q, vld_d;
   logic             in_rdy_q, in_rdy_d;
   logic             busy_q, busy_d;
   logic             accept, pop, timeout_hit;
   beat_t            new_beat;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] idle_q, idle_d;

   assign timeout_hit = (idle_q >= TO_W'(TIMEOUT));

   // Idle counter: runs while a partial burst waits in IDLE, cleared otherwise
   always_comb begin
      idle_d = '0;
      if (state_q == IDLE && state_d == IDLE && bus.count != '0 && bus.count < BL_C)
         idle_d = idle_q + TO_W'(1);
   end

   // Idle counter register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) idle_q <= '0;
      else           idle_q <= idle_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, burst bookkeeping and skid buffer update
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      beat_d        = beat_q;
      flush_pend_d  = flush_pend_q;
      skid_d        = skid_q;
      vld_d         = vld_q;
      accept        = bus.in0_V_V_TVALID & in_rdy_q;
      pop           = vld_q[0] & bus.out_V_V_TREADY;
      new_beat.last = (beat_q == len_q - CNT_W'(1));
      new_beat.data = bus.in0_V_V_TDATA;

      case (state_q)
         IDLE: begin
            if (bus.count >= BL_C) begin
               len_d   = BL_C;
               beat_d  = '0;
               state_d = BURST;
            end else if (bus.count != '0 && (flush_pend_q || timeout_hit)) begin
               len_d        = bus.count;
               beat_d       = '0;
               state_d      = BURST;
               flush_pend_d = 1'b0;
            end else if (bus.count == '0) begin
               flush_pend_d = 1'b0;
            end
         end
         BURST: begin
            if (accept) begin
               beat_d = beat_q + CNT_W'(1);
               if (new_beat.last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.flush) flush_pend_d = 1'b1;

      // pop shifts the queue forward; a push lands in the first free slot
      if (pop) begin
         skid_d[0] = skid_q[1];
         vld_d     = {1'b0, vld_q[1]};
      end
      if (accept) begin
         if (vld_d[0]) begin
            skid_d[1] = new_beat;
            vld_d[1]  = 1'b1;
         end else begin
            skid_d[0] = new_beat;
            vld_d[0]  = 1'b1;
         end
      end

      in_rdy_d = (state_d == BURST) && !vld_d[1];
      busy_d   = (state_d == BURST) || vld_d[0];
   end

   // State, counters, skid and registered outputs
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         skid_q       <= '{default: '0};
         vld_q        <= '0;
         in_rdy_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         skid_q       <= skid_d;
         vld_q        <= vld_d;
         in_rdy_q     <= in_rdy_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.in0_V_V_TREADY = in_rdy_q;
   assign bus.out_V_V_TDATA  = skid_q[0].data;
   assign bus.out_V_V_TLAST  = skid_q[0].last;
   assign bus.out_V_V_TVALID = vld_q[0];
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: models the upstream FIFO as a queue,
// predicts the burst stream from the burst/flush rules, and checks every
// delivered beat plus skid occupancy invariants from a separate monitor.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned BURST_LEN = 8;
   localparam int unsigned TIMEOUT   = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_burst_reader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   fifo_burst_reader #(
      .WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .ap_clk  (clk),
      .ap_rst_n(rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   int outst = 0;
   int cyc   = 0;
   int ready_mode = 1;   // 0 random, 1 always, 2 toggle
   bit vld_gate   = 1'b0;
   bit flush_req  = 1'b0;
   bit rdy_tog    = 1'b0;
   logic [WIDTH:0]   exp_q [$];
   logic [WIDTH-1:0] fifo_q [$];
   int beat_cyc [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired, %0d beats seen, %0d expected pending", name, n_out, exp_q.size());
   endtask

   // Monitor: skid invariants and scoreboard compare of each delivered beat
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         check("out_valid", 32'(bus.out_V_V_TVALID), 32'(outst > 0));
         check("skid_depth", 32'(outst <= 2), 32'd1);
         if (bus.in0_V_V_TREADY) check("in_ready_room", 32'(outst < 2), 32'd1);
         if (bus.out_V_V_TVALID && bus.out_V_V_TREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_beat: got data 0x%0h last %0b expected none",
                        bus.out_V_V_TDATA, bus.out_V_V_TLAST);
            end else begin
               check("beat", 32'({bus.out_V_V_TLAST, bus.out_V_V_TDATA}), 32'(exp_q.pop_front()));
            end
            outst--;
            n_out++;
            beat_cyc.push_back(cyc);
         end
         if (bus.in0_V_V_TVALID && bus.in0_V_V_TREADY) outst++;
      end
   end

   task automatic drive();
      bus.count          = CNT_W'(fifo_q.size());
      bus.in0_V_V_TVALID = (fifo_q.size() > 0) && (!vld_gate || ($urandom_range(3) != 0));
      bus.in0_V_V_TDATA  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      rdy_tog            = ~rdy_tog;
      case (ready_mode)
         0:       bus.out_V_V_TREADY = ($urandom_range(2) != 0);
         2:       bus.out_V_V_TREADY = rdy_tog;
         default: bus.out_V_V_TREADY = 1'b1;
      endcase
      bus.flush = flush_req;
      flush_req = 1'b0;
   endtask

   // One clock: note the read that will happen at the edge, then update FIFO model
   task automatic cycle();
      bit acc;
      @(negedge clk);
      acc = bus.in0_V_V_TVALID && bus.in0_V_V_TREADY;
      @(posedge clk);
      #1;
      if (acc && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Load n words; every BURST_LEN-th word closes a full burst, the tail
   // (released later by flush or timeout) ends on the final word.
   task automatic load(input int n, input bit seq, input logic [WIDTH-1:0] base);
      int full;
      logic [WIDTH-1:0] w;
      logic last;
      full = (n / int'(BURST_LEN)) * int'(BURST_LEN);
      for (int i = 0; i < n; i++) begin
         w = seq ? base + WIDTH'(i) : WIDTH'($urandom);
         if (i < full) last = ((i % int'(BURST_LEN)) == int'(BURST_LEN) - 1);
         else          last = (i == n - 1);
         fifo_q.push_back(w);
         exp_q.push_back({last, w});
      end
      drive();
   endtask

   task automatic pulse_flush();
      flush_req = 1'b1;
      cycle();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.busy) && k < budget) begin
         cycle();
         k++;
      end
      if (k >= budget) timeout_fail(name);
   endtask

   task automatic wait_out(input string name, input int target, input int budget);
      int k;
      k = 0;
      while (n_out < target && k < budget) begin
         cycle();
         k++;
      end
      if (k >= budget) timeout_fail(name);
   endtask

   initial begin
      int n0, c0, n, d;
      bus.count = '0;
      bus.flush = 1'b0;
      bus.in0_V_V_TDATA  = '0;
      bus.in0_V_V_TVALID = 1'b0;
      bus.out_V_V_TREADY = 1'b1;
      run(3);
      check("rst_in_ready", 32'(bus.in0_V_V_TREADY), 32'd0);
      check("rst_out_valid", 32'(bus.out_V_V_TVALID), 32'd0);
      check("rst_out_data", 32'(bus.out_V_V_TDATA), 32'd0);
      check("rst_out_last", 32'(bus.out_V_V_TLAST), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      run(2);

      // Full burst at full throughput: 8 consecutive beats
      ready_mode = 1; vld_gate = 1'b0;
      beat_cyc.delete();
      load(8, 1'b1, 8'h10);
      wait_idle("full_burst", 200);
      check("full_beats", 32'(beat_cyc.size()), 32'd8);
      if (beat_cyc.size() == 8) check("full_span", 32'(beat_cyc[7] - beat_cyc[0]), 32'd7);

      // Partial burst released by flush, nothing afterwards
      n0 = n_out;
      load(3, 1'b1, 8'h40);
      run(20);
      check("partial_held", 32'(n_out - n0), 32'd0);
      pulse_flush();
      wait_idle("flush_burst", 200);
      check("flush_beats", 32'(n_out - n0), 32'd3);
      run(30);
      check("flush_no_more", 32'(n_out - n0), 32'd3);

      // Static partial count: timeout release or indefinite hold
      n0 = n_out;
      beat_cyc.delete();
      c0 = cyc;
      load(5, 1'b1, 8'h60);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      wait_idle("timeout_burst", 400);
      check("timeout_beats", 32'(n_out - n0), 32'd5);
      if (beat_cyc.size() > 0) begin
         check("timeout_start", 32'((beat_cyc[0] - c0) >= int'(TIMEOUT) &&
                                   (beat_cyc[0] - c0) <= int'(TIMEOUT) + 6), 32'd1);
      end
`else
      run(1000);
      check("no_timeout_hold", 32'(n_out - n0), 32'd0);
      pulse_flush();
      wait_idle("hold_flush", 200);
      check("hold_flush_beats", 32'(n_out - n0), 32'd5);
`endif

      // Toggling downstream ready with gated input valid
      ready_mode = 2; vld_gate = 1'b1;
      n0 = n_out;
      load(8, 1'b0, '0);
      wait_idle("toggle_burst", 400);
      check("toggle_beats", 32'(n_out - n0), 32'd8);

      // 20 words: two full bursts, 4 held until flush
      ready_mode = 0;
      n0 = n_out;
      load(20, 1'b0, '0);
      wait_out("two_bursts", n0 + 16, 600);
`ifndef FIFO_BURST_READER_TIMEOUT_EN
      run(40);
      check("tail_held", 32'(n_out - n0), 32'd16);
      check("tail_in_fifo", 32'(fifo_q.size()), 32'd4);
`endif
      pulse_flush();
      wait_idle("tail_flush", 600);
      check("twenty_beats", 32'(n_out - n0), 32'd20);

      // Randomized scenarios: random length, ready pattern and flush timing
      for (int s = 0; s < 15; s++) begin
         ready_mode = int'($urandom_range(2));
         vld_gate   = 1'($urandom_range(1));
         n  = int'($urandom_range(30, 1));
         d  = int'($urandom_range(40));
         n0 = n_out;
         load(n, 1'b0, '0);
         run(d);
         pulse_flush();
         wait_idle("random_scn", 2000);
         check("random_beats", 32'(n_out - n0), 32'(n));
      end

      // Reset in the middle of a burst
      ready_mode = 1; vld_gate = 1'b0;
      n0 = n_out;
      load(8, 1'b1, 8'hA0);
      wait_out("pre_reset", n0 + 3, 100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_V_V_TVALID), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in0_V_V_TREADY), 32'd0);
      exp_q.delete();
      fifo_q.delete();
      outst = 0;
      drive();
      run(2);
      rst_n = 1'b1;
      run(2);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("post_rst_in_ready", 32'(bus.in0_V_V_TREADY), 32'd0);
      n0 = n_out;
      load(9, 1'b1, 8'hB0);
      pulse_flush();
      wait_idle("post_reset", 300);
      check("post_rst_beats", 32'(n_out - n0), 32'd9);

      run(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
